ecc_encoder: RTL and testbench
==============================

// Module: ecc_encoder
// PURPOSE
//  Extended-Hamming (SECDED) encoder for the memory write path. Takes a data word,
//  computes Hamming parity plus an overall parity bit, and emits a registered codeword.
//  Sits between the write-data source and the memory array. The paired decoder
//  corrects 1-bit errors and detects 2-bit errors.
// PARAMETERS
//  data_bit_width      64  data word width (D)
//  redundant_bit_width  8  check bits (R): R-1 Hamming parity bits + 1 overall parity
//  - Elaboration error unless 2**(R-1) >= D + R. Defaults: 2**7=128 >= 72.
// PORTS
//  clk            in   1    clock; all state on rising edge
//  rst            in   1    asynchronous, active-high reset
//  enc_valid_in   in   1    enc_data_in is valid this cycle
//  enc_data_in    in   D    data word
//  enc_valid_out  out  1    enc_data_out holds a new codeword
//  enc_data_out   out  D+R  codeword, registered
// BEHAVIOUR
//  - Reset (async assert, sync release):
//      enc_data_out = 0; enc_valid_out = 0. All-zero is a legal codeword.
//  - Codeword layout, positions 1..D+R-1 (Hamming space) plus bit 0:
//      * Parity bit p_k sits at position 2**k, for k=0..R-2 (1,2,4,8,16,32,64).
//      * Data bits fill the remaining positions in ascending order:
//        data[0]->3, data[1]->5, data[2]->6, data[3]->7, data[4]->9 ... data[D-1]->D+R-1 (71).
//      * p_k = XOR of all data positions whose index has bit k set (even parity).
//      * enc_data_out[0] = XOR of positions D+R-1..1 (overall even parity).
//        Whole codeword therefore has even weight.
//  - Encode logic is purely combinational from enc_data_in. Derive mapping via
//    generate loops from the parameters; no hard-coded masks.
//  - Latency: exactly 1 cycle.
//  - On each rising edge with enc_valid_in=1: enc_data_out <= codeword(enc_data_in);
//    enc_valid_out <= 1.
//  - On an edge with enc_valid_in=0: enc_data_out holds its value; enc_valid_out <= 0.
//  - Back-to-back valid inputs give back-to-back outputs. No backpressure; full throughput.
//  - Reset mid-stream discards the in-flight word. First output after reset release
//    needs a fresh valid input.
//  - X on enc_data_in while enc_valid_in=0 must not disturb the held output.
//  - Minimum distance of the code >= 4. Every nonzero data word yields codeword weight >= 4.
// TESTING
//  1. rst=1 asynchronously mid-cycle -> enc_data_out=0, enc_valid_out=0 immediately.
//  2. valid=1, data=64'h0 -> next cycle enc_data_out=72'h0, enc_valid_out=1.
//  3. valid=1, data=64'h1 -> enc_data_out=72'h00_0000_0000_0000_000F.
//     data=64'h2 -> 72'h...0033.
//  4. valid=1, data=64'h8000_0000_0000_0000 -> enc_data_out=72'h81_0000_0000_0000_0017.
//  5. Stream 1000 random words with valid toggling randomly, compared with a reference model:
//     - output equals model 1 cycle later; held when valid=0;
//     - every codeword has even parity;
//     - every one-hot input gives codeword weight >= 4.
//  6. Assert rst during a back-to-back burst -> outputs clear; after release,
//     next valid word encodes correctly.

Source files
------------

// File: rtl/ecc_encoder.sv
// Extended-Hamming (SECDED) encoder for the memory write path.
// Hamming parity at power-of-two positions, overall even parity at bit 0, one register stage.
module ecc_encoder #(
  parameter int data_bit_width      = 64,
  parameter int redundant_bit_width = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          enc_valid_in,
  input  logic [data_bit_width-1:0]                     enc_data_in,
  output logic                                          enc_valid_out,
  output logic [data_bit_width+redundant_bit_width-1:0] enc_data_out
);

  localparam int CW_W  = data_bit_width + redundant_bit_width;
  localparam int PAR_N = redundant_bit_width - 1;

  if ((2 ** PAR_N) < CW_W) begin : g_bad_params
    $error("ecc_encoder: 2**(redundant_bit_width-1) must be >= data_bit_width + redundant_bit_width");
  end

  function automatic logic is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Position of data bit idx: the idx-th non-power-of-two index in 1..CW_W-1.
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p < CW_W; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic logic [CW_W-1:1] cover_mask(input int k);
    logic [CW_W-1:1] m;
    m = '0;
    for (int p = 1; p < CW_W; p++) begin
      m[p] = !is_pow2(p) && (((p >> k) & 1) == 1);
    end
    return m;
  endfunction

  logic [CW_W-1:1] spread_p0;
  logic [PAR_N-1:0] par_p0;
  logic [CW_W-1:1] ham_p0;
  logic [CW_W-1:0] codeword_p0;

  // Stage p0: combinational encode of enc_data_in
  for (genvar i = 0; i < data_bit_width; i++) begin : g_map
    localparam int POS = data_pos(i);
    assign spread_p0[POS] = enc_data_in[i];
  end

  for (genvar k = 0; k < PAR_N; k++) begin : g_par
    localparam logic [CW_W-1:1] MASK = cover_mask(k);
    assign spread_p0[2 ** k] = 1'b0;
    assign par_p0[k]         = ^(spread_p0 & MASK);
  end

  always_comb begin
    ham_p0 = spread_p0;
    for (int k = 0; k < PAR_N; k++) begin
      ham_p0[2 ** k] = par_p0[k];
    end
    codeword_p0 = {ham_p0, ^ham_p0};
  end

  // Stage p1: output register; data holds while no new word arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_valid_out <= 1'b0;
      enc_data_out  <= '0;
    end else begin
      enc_valid_out <= enc_valid_in;
      if (enc_valid_in) enc_data_out <= codeword_p0;
    end
  end

endmodule

// File: tb/tb_ecc_encoder.sv
// Directed and random checks for ecc_encoder (D=64, R=8).
module tb_ecc_encoder;

  logic        clk;
  logic        rst;
  logic        enc_valid_in;
  logic [63:0] enc_data_in;
  logic        enc_valid_out;
  logic [71:0] enc_data_out;

  int vectors;
  int miscompares;

  ecc_encoder #(
    .data_bit_width     (64),
    .redundant_bit_width(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_valid_in (enc_valid_in),
    .enc_data_in  (enc_data_in),
    .enc_valid_out(enc_valid_out),
    .enc_data_out (enc_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: place data bits, then choose parity bits so the XOR of set positions is zero.
  function automatic logic [71:0] model(input logic [63:0] d);
    logic [71:0] c;
    int j;
    int syn;
    c = '0;
    j = 0;
    syn = 0;
    for (int p = 1; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        if (d[j]) syn = syn ^ p;
        j++;
      end
    end
    for (int k = 0; k < 7; k++) c[1 << k] = syn[k];
    c[0] = ^c[71:1];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic exp_vld, input logic [71:0] exp_data);
    vectors++;
    if (enc_valid_out !== exp_vld || enc_data_out !== exp_data) begin
      miscompares++;
      $display("FAIL %s: got vld=%b data=%h, expected vld=%b data=%h",
               name, enc_valid_out, enc_data_out, exp_vld, exp_data);
    end
  endtask

  task automatic test_reset();
    enc_valid_in = 1'b1;
    enc_data_in  = 64'h1;
    rst = 1'b0;
    tick();
    check_out("pre_reset_word", 1'b1, 72'h00_0000_0000_0000_000F);
    #2;
    rst = 1'b1;
    #1;
    check_out("async_reset", 1'b0, 72'h0);
    tick();
    check_out("reset_held", 1'b0, 72'h0);
    #2;
    rst = 1'b0;
    enc_valid_in = 1'b0;
    tick();
    check_out("after_release_idle", 1'b0, 72'h0);
  endtask

  task automatic test_directed();
    logic [63:0] din  [5];
    logic [71:0] dexp [5];
    din[0] = 64'h0;                   dexp[0] = 72'h00_0000_0000_0000_0000;
    din[1] = 64'h1;                   dexp[1] = 72'h00_0000_0000_0000_000F;
    din[2] = 64'h2;                   dexp[2] = 72'h00_0000_0000_0000_0033;
    din[3] = 64'h4;                   dexp[3] = 72'h00_0000_0000_0000_0055;
    din[4] = 64'h8000_0000_0000_0000; dexp[4] = 72'h81_0000_0000_0000_0017;
    for (int i = 0; i < 5; i++) begin
      enc_valid_in = 1'b1;
      enc_data_in  = din[i];
      tick();
      check_out($sformatf("directed_%0d", i), 1'b1, dexp[i]);
    end
  endtask

  task automatic test_hold();
    enc_valid_in = 1'b0;
    enc_data_in  = 'x;
    tick();
    check_out("hold_x_1", 1'b0, 72'h81_0000_0000_0000_0017);
    enc_data_in = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    check_out("hold_data_2", 1'b0, 72'h81_0000_0000_0000_0017);
  endtask

  task automatic test_one_hot();
    logic [71:0] exp_cw;
    for (int i = 0; i < 64; i++) begin
      enc_valid_in = 1'b1;
      enc_data_in  = 64'h1 << i;
      tick();
      exp_cw = model(enc_data_in);
      check_out($sformatf("one_hot_%0d", i), 1'b1, exp_cw);
      vectors++;
      if ($countones(enc_data_out) < 4) begin
        miscompares++;
        $display("FAIL one_hot_weight_%0d: weight=%0d, expected >= 4", i, $countones(enc_data_out));
      end
    end
  endtask

  task automatic test_random();
    logic        v;
    logic [63:0] d;
    logic        exp_vld;
    logic [71:0] exp_data;
    exp_data = enc_data_out;
    for (int n = 0; n < 1000; n++) begin
      v = 1'($urandom_range(0, 1));
      d = {$urandom(), $urandom()};
      enc_valid_in = v;
      enc_data_in  = v ? d : 'x;
      tick();
      exp_vld = v;
      if (v) exp_data = model(d);
      check_out("random", exp_vld, exp_data);
      vectors++;
      if ((^enc_data_out) !== 1'b0) begin
        miscompares++;
        $display("FAIL random_parity: data=%h has odd weight, expected even", enc_data_out);
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    logic [63:0] burst [3];
    burst[0] = 64'hDEAD_BEEF_0123_4567;
    burst[1] = 64'h0F0F_F0F0_AAAA_5555;
    burst[2] = 64'h1234_5678_9ABC_DEF0;
    for (int i = 0; i < 3; i++) begin
      enc_valid_in = 1'b1;
      enc_data_in  = burst[i];
      tick();
      check_out($sformatf("burst_%0d", i), 1'b1, model(burst[i]));
    end
    enc_data_in = 64'hCAFE_F00D_CAFE_F00D;
    #2;
    rst = 1'b1;
    #1;
    check_out("burst_async_reset", 1'b0, 72'h0);
    tick();
    check_out("burst_reset_edge", 1'b0, 72'h0);
    #2;
    rst = 1'b0;
    enc_valid_in = 1'b0;
    tick();
    check_out("burst_release_idle", 1'b0, 72'h0);
    enc_valid_in = 1'b1;
    enc_data_in  = 64'h8000_0000_0000_0000;
    tick();
    check_out("burst_resume", 1'b1, 72'h81_0000_0000_0000_0017);
    enc_valid_in = 1'b0;
    tick();
    check_out("burst_resume_drop", 1'b0, 72'h81_0000_0000_0000_0017);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    enc_valid_in = 1'b0;
    enc_data_in  = '0;
    tick();
    tick();
    check_out("power_on_reset", 1'b0, 72'h0);
    test_reset();
    test_directed();
    test_hold();
    test_one_hot();
    test_random();
    test_back_to_back_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
